free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter NUM_P_REGS, default 64, number of physical registers.
REQ-002 SHALL have parameter NUM_A_REGS, default 32, number of architectural registers; physical registers 0..NUM_A_REGS-1 are mapped at reset.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit, reset: synchronous, active-low.
REQ-005 SHALL have port en_alloc0_i, input, 1 bit, the rename stage consumes alloc_preg0_o this cycle.
REQ-006 SHALL have port en_alloc1_i, input, 1 bit, the rename stage consumes alloc_preg1_o this cycle.
REQ-007 SHALL have port alloc_preg0_o, output, $clog2(NUM_P_REGS) bits, the next free physical register, which feeds instr0_dest_i of the reorder buffer.
REQ-008 SHALL have port alloc_preg1_o, output, $clog2(NUM_P_REGS) bits, the free register after alloc_preg0_o.
REQ-009 SHALL have port en_free0_i, input, 1 bit, retire slot 0 returns a register; driven by the ROB en_retire_dest0_o.
REQ-010 SHALL have port en_free1_i, input, 1 bit, retire slot 1 returns a register; driven by the ROB en_retire_dest1_o.
REQ-011 SHALL have port free_preg0_i, input, $clog2(NUM_P_REGS) bits, register returned by slot 0, taken from retire_old_dest0_o.
REQ-012 SHALL have port free_preg1_i, input, $clog2(NUM_P_REGS) bits, register returned by slot 1, taken from retire_old_dest1_o.
REQ-013 SHALL have port stall_o, output, 1 bit, high when fewer than 2 registers are free.
REQ-014 SHALL have port free_count_o, output, $clog2(NUM_P_REGS)+1 bits, number of free registers.
REQ-015 SHALL have port err_o, output, 1 bit, sticky error flag (see Configuration).

Function
REQ-016 SHALL store free registers in a circular FIFO of depth NUM_P_REGS, with head pointer, tail pointer and count registers.
REQ-017 SHALL drive alloc_preg0_o = fifo[head] and alloc_preg1_o = fifo[(head+1) mod NUM_P_REGS] combinationally from registered state, so there are zero cycles of allocation latency.
REQ-018 SHALL set stall_o = (count < 2) and free_count_o = count, both combinationally.
REQ-019 SHALL ignore both en_alloc inputs when stall_o is high; the upstream stage must hold until stall_o drops.
REQ-020 SHALL treat en_alloc1_i without en_alloc0_i as consuming only alloc_preg0_o, so one register is popped in that case.
REQ-021 SHALL advance head by the number of registers popped (0, 1 or 2), with mod NUM_P_REGS wrap.
REQ-022 SHALL, on each enabled free, write the register at tail and advance tail, slot 0 before slot 1, with mod NUM_P_REGS wrap.
REQ-023 SHALL silently ignore a free of physical register 0 (the zero mapping), with no write and no count change.
REQ-024 SHALL update count as count + frees - pops when alloc and free occur in the same cycle.
REQ-025 SHALL NOT make a register freed in cycle N visible on alloc_preg outputs before cycle N+1; there is no free-to-alloc bypass.
REQ-026 SHALL drop a free that would make count exceed NUM_P_REGS-1 and SHALL set err_o in that case, in both configurations.

Reset
REQ-027 SHALL, while rst_n_i is low at a clock edge, load fifo[i] = NUM_A_REGS+i for i < NUM_P_REGS-NUM_A_REGS, with head=0, tail=NUM_P_REGS-NUM_A_REGS, count=NUM_P_REGS-NUM_A_REGS and err_o=0.
REQ-028 SHALL, after reset with default parameters, give alloc_preg0_o=32, alloc_preg1_o=33, stall_o=0, free_count_o=32 and err_o=0.
REQ-029 SHALL give reset priority over any same-cycle alloc or free, so mid-operation requests are discarded.

Configuration
REQ-030 SHALL, when macro FREE_LIST_CHECK_EN is defined, keep an NUM_P_REGS-bit in-list vector; a free of a register already in the list is dropped, and any free whose index is >= NUM_P_REGS is also dropped, with err_o set in both cases.
REQ-031 SHALL, when FREE_LIST_CHECK_EN is undefined, omit the vector and accept all frees except those covered by REQ-023 and REQ-026, with err_o set only by REQ-026.

Verification
REQ-032 SHALL verify: reset, then en_alloc0_i=en_alloc1_i=1 for one cycle -> next cycle alloc_preg0_o=34, alloc_preg1_o=35, free_count_o=30.
REQ-033 SHALL verify: allocate 2 per cycle for 15 cycles -> free_count_o=2 and stall_o=0; allocate 2 more -> stall_o=1 and further allocs are ignored with count held at 0.
REQ-034 SHALL verify: with count=0, en_free0_i=1 with preg 5 and en_free1_i=1 with preg 9 in the same cycle as en_alloc0_i=1 -> alloc is ignored, then next cycle alloc_preg0_o=5, alloc_preg1_o=9, stall_o=0.
REQ-035 SHALL verify: a simultaneous single alloc and single free of preg 7 -> count unchanged, 7 not visible until it reaches head, and correct tail wrap past index 63.
REQ-036 SHALL verify: free preg 0 -> count unchanged and err_o=0; with FREE_LIST_CHECK_EN, a free of preg 40 while 40 is still in the list -> err_o=1 and count unchanged.
REQ-037 SHALL verify: assert rst_n_i=0 during a two-wide alloc/free cycle -> next cycle the REQ-028 values are shown.

Source files
------------

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Physical-register free list for a two-wide rename stage. Free registers are
//   held in a circular FIFO. The two oldest entries are offered combinationally
//   for allocation, and up to two registers come back per cycle from retire.
//
//   Build option: define FREE_LIST_CHECK_EN to keep an in-list vector. With it,
//   a free of a register already in the list, or of an out-of-range index, is
//   dropped and flags err_o.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_n_i        synchronous active-low reset
//   en_alloc0_i    rename consumes alloc_preg0_o this cycle
//   en_alloc1_i    rename consumes alloc_preg1_o this cycle
//   alloc_preg0_o  next free physical register (fifo[head])
//   alloc_preg1_o  free register after alloc_preg0_o (fifo[head+1])
//   en_free0_i     retire slot 0 returns free_preg0_i
//   en_free1_i     retire slot 1 returns free_preg1_i
//   free_preg0_i   register returned by retire slot 0
//   free_preg1_i   register returned by retire slot 1
//   stall_o        fewer than two registers are free; allocations are ignored
//   free_count_o   number of free registers
//   err_o          sticky: a free was dropped (overflow, or duplicate/range
//                  violation when checking is built in)
// -----------------------------------------------------------------------------
module free_list #(
    parameter int NUM_P_REGS = 64,
    parameter int NUM_A_REGS = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          en_alloc0_i,
    input  logic                          en_alloc1_i,
    output logic [$clog2(NUM_P_REGS)-1:0] alloc_preg0_o,
    output logic [$clog2(NUM_P_REGS)-1:0] alloc_preg1_o,
    input  logic                          en_free0_i,
    input  logic                          en_free1_i,
    input  logic [$clog2(NUM_P_REGS)-1:0] free_preg0_i,
    input  logic [$clog2(NUM_P_REGS)-1:0] free_preg1_i,
    output logic                          stall_o,
    output logic [$clog2(NUM_P_REGS):0]   free_count_o,
    output logic                          err_o
);

    localparam int PW       = $clog2(NUM_P_REGS);
    localparam int CW       = PW + 1;
    localparam int NUM_INIT = NUM_P_REGS - NUM_A_REGS;

    // Register 0 is never returned, so at most NUM_P_REGS-1 entries are free.
    localparam logic [CW-1:0] CNT_MAX = CW'(NUM_P_REGS - 1);

    logic [PW-1:0] fifo_q [NUM_P_REGS];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          err_q;

    logic          stall;
    logic [1:0]    n_pop;
    logic [1:0]    acc;
    logic [1:0]    n_acc;
    logic          err_set;
    logic          bad;
    logic [CW-1:0] cnt_run;
    logic [PW-1:0] tail_slot1;
    logic          fen [2];
    logic [PW-1:0] fpr [2];

    // Pointer advance modulo NUM_P_REGS; also correct for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [1:0] inc);
        logic [PW:0] sum;
        sum = {1'b0, ptr} + (PW+1)'(inc);
        if (sum >= (PW+1)'(NUM_P_REGS)) sum = sum - (PW+1)'(NUM_P_REGS);
        return sum[PW-1:0];
    endfunction

`ifdef FREE_LIST_CHECK_EN
    logic [NUM_P_REGS-1:0] in_list_q;
    logic [NUM_P_REGS-1:0] in_list_nxt;
`endif

    // Allocation view: zero-latency, straight from registered state.
    always_comb begin
        alloc_preg0_o = fifo_q[head_q];
        alloc_preg1_o = fifo_q[ptr_add(head_q, 2'd1)];
        stall         = (count_q < CW'(2));
        stall_o       = stall;
        free_count_o  = count_q;
        err_o         = err_q;
    end

    // Pops: a lone en_alloc1_i still only consumes the head entry.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        n_pop = 2'd0;
        if (!stall) begin
            if (en_alloc0_i && en_alloc1_i)      n_pop = 2'd2;
            else if (en_alloc0_i || en_alloc1_i) n_pop = 2'd1;
        end
    end

    // Frees: slot 0 is considered before slot 1. The capacity check sees the
    // count after this cycle's pops and after any earlier accepted slot.
    always_comb begin
        fen[0]  = en_free0_i;
        fen[1]  = en_free1_i;
        fpr[0]  = free_preg0_i;
        fpr[1]  = free_preg1_i;
        acc     = 2'b00;
        err_set = 1'b0;
        bad     = 1'b0;
        cnt_run = count_q - CW'(n_pop);
`ifdef FREE_LIST_CHECK_EN
        // Registers leaving at the head this cycle are no longer in the list,
        // so freeing one back in the same cycle is legal.
        in_list_nxt = in_list_q;
        if (n_pop != 2'd0) in_list_nxt[alloc_preg0_o] = 1'b0;
        if (n_pop == 2'd2) in_list_nxt[alloc_preg1_o] = 1'b0;
`endif
        for (int s = 0; s < 2; s++) begin
            if (fen[s] && fpr[s] != '0) begin
                bad = 1'b0;
`ifdef FREE_LIST_CHECK_EN
                bad = ({1'b0, fpr[s]} >= CW'(NUM_P_REGS)) || in_list_nxt[fpr[s]];
`endif
                if (bad || cnt_run >= CNT_MAX) begin
                    err_set = 1'b1;
                end else begin
                    acc[s]  = 1'b1;
                    cnt_run = cnt_run + CW'(1);
`ifdef FREE_LIST_CHECK_EN
                    in_list_nxt[fpr[s]] = 1'b1;
`endif
                end
            end
        end
        n_acc      = {1'b0, acc[0]} + {1'b0, acc[1]};
        tail_slot1 = acc[0] ? ptr_add(tail_q, 2'd1) : tail_q;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n_i) begin
            // NOTE: the FIFO storage is reset because it must come up holding the initial free registers.
            for (int i = 0; i < NUM_P_REGS; i++) begin
                fifo_q[i] <= (i < NUM_INIT) ? PW'(NUM_A_REGS + i) : '0;
            end
            head_q  <= '0;
            tail_q  <= PW'(NUM_INIT);
            count_q <= CW'(NUM_INIT);
            err_q   <= 1'b0;
        end else begin
            if (acc[0]) fifo_q[tail_q]     <= free_preg0_i;
            if (acc[1]) fifo_q[tail_slot1] <= free_preg1_i;
            head_q  <= ptr_add(head_q, n_pop);
            tail_q  <= ptr_add(tail_q, n_acc);
            count_q <= cnt_run;
            if (err_set) err_q <= 1'b1;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_P_REGS; i++) begin
                in_list_q[i] <= (i >= NUM_A_REGS);
            end
        end else begin
            in_list_q <= in_list_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
//   Self-checking bench for free_list. A queue-based model of the free list is
//   updated on each rising edge. One compare process checks every DUT output
//   against it on each falling edge. Directed sequences pin known values, and a
//   randomized phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_free_list;

    localparam int NP = 64;
    localparam int NA = 32;
    localparam int PW = $clog2(NP);
    localparam int CW = PW + 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          en_alloc0_i = 1'b0;
    logic          en_alloc1_i = 1'b0;
    logic [PW-1:0] alloc_preg0_o;
    logic [PW-1:0] alloc_preg1_o;
    logic          en_free0_i = 1'b0;
    logic          en_free1_i = 1'b0;
    logic [PW-1:0] free_preg0_i = '0;
    logic [PW-1:0] free_preg1_i = '0;
    logic          stall_o;
    logic [CW-1:0] free_count_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    free_list #(.NUM_P_REGS(NP), .NUM_A_REGS(NA)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .en_alloc0_i  (en_alloc0_i),
        .en_alloc1_i  (en_alloc1_i),
        .alloc_preg0_o(alloc_preg0_o),
        .alloc_preg1_o(alloc_preg1_o),
        .en_free0_i   (en_free0_i),
        .en_free1_i   (en_free1_i),
        .free_preg0_i (free_preg0_i),
        .free_preg1_i (free_preg1_i),
        .stall_o      (stall_o),
        .free_count_o (free_count_o),
        .err_o        (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: the ordered list of free registers plus a sticky error.
    int fq[$];
    bit err_m = 1'b0;
    int pops;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_free(input logic en, input logic [PW-1:0] p);
        bit dup;
        dup = 1'b0;
        if (en && p != 0) begin
`ifdef FREE_LIST_CHECK_EN
            foreach (fq[k]) if (fq[k] == int'(p)) dup = 1'b1;
`endif
            if (dup)                    err_m = 1'b1;
            else if (fq.size() >= NP-1) err_m = 1'b1;
            else                        fq.push_back(int'(p));
        end
    endtask

    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            fq.delete();
            for (int i = NA; i < NP; i++) fq.push_back(i);
            err_m = 1'b0;
        end else begin
            pops = 0;
            if (fq.size() >= 2) begin
                if (en_alloc0_i && en_alloc1_i)      pops = 2;
                else if (en_alloc0_i || en_alloc1_i) pops = 1;
            end
            repeat (pops) void'(fq.pop_front());
            model_free(en_free0_i, free_preg0_i);
            model_free(en_free1_i, free_preg1_i);
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("model free_count", 32'(free_count_o), fq.size());
            check("model stall", 32'(stall_o), int'(fq.size() < 2));
            check("model err", 32'(err_o), int'(err_m));
            if (fq.size() >= 1) check("model alloc0", 32'(alloc_preg0_o), fq[0]);
            if (fq.size() >= 2) check("model alloc1", 32'(alloc_preg1_o), fq[1]);
        end
    end

    // Drive one cycle of inputs, then return at the following falling edge.
    task automatic step(input bit r, input bit a0, input bit a1,
                        input bit f0, input int p0, input bit f1, input int p1);
        rst_n_i      = r;
        en_alloc0_i  = a0;
        en_alloc1_i  = a1;
        en_free0_i   = f0;
        free_preg0_i = PW'(p0);
        en_free1_i   = f1;
        free_preg1_i = PW'(p1);
        @(negedge clk_i);
    endtask

    initial begin
        // Reset with junk requests present.
        step(0, 1, 1, 1, 3, 1, 4);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        check("reset alloc0", 32'(alloc_preg0_o), 32);
        check("reset alloc1", 32'(alloc_preg1_o), 33);
        check("reset stall", 32'(stall_o), 0);
        check("reset count", 32'(free_count_o), 32);
        check("reset err", 32'(err_o), 0);

        // Two-wide allocate.
        step(1, 1, 1, 0, 0, 0, 0);
        check("alloc2 alloc0", 32'(alloc_preg0_o), 34);
        check("alloc2 alloc1", 32'(alloc_preg1_o), 35);
        check("alloc2 count", 32'(free_count_o), 30);

        // Drain to the stall boundary.
        step(0, 0, 0, 0, 0, 0, 0);
        repeat (15) step(1, 1, 1, 0, 0, 0, 0);
        check("drain count", 32'(free_count_o), 2);
        check("drain stall", 32'(stall_o), 0);
        check("drain alloc0", 32'(alloc_preg0_o), 62);
        check("drain alloc1", 32'(alloc_preg1_o), 63);
        step(1, 1, 1, 0, 0, 0, 0);
        check("empty count", 32'(free_count_o), 0);
        check("empty stall", 32'(stall_o), 1);
        step(1, 1, 1, 0, 0, 0, 0);
        check("stalled alloc count", 32'(free_count_o), 0);

        // Frees while empty; the same-cycle alloc is ignored.
        step(1, 1, 0, 1, 5, 1, 9);
        check("refill alloc0", 32'(alloc_preg0_o), 5);
        check("refill alloc1", 32'(alloc_preg1_o), 9);
        check("refill stall", 32'(stall_o), 0);
        check("refill count", 32'(free_count_o), 2);

        // Fill so the tail wraps past index 63.
        for (int i = 0; i < 15; i++) step(1, 0, 0, 1, 10 + 2*i, 1, 11 + 2*i);
        check("wrap count", 32'(free_count_o), 32);
        step(1, 1, 0, 1, 7, 0, 0);
        check("alloc+free count", 32'(free_count_o), 32);
        check("alloc+free alloc0", 32'(alloc_preg0_o), 9);
        check("alloc+free alloc1", 32'(alloc_preg1_o), 10);
        repeat (30) step(1, 1, 0, 0, 0, 0, 0);
        check("near head alloc0", 32'(alloc_preg0_o), 39);
        check("near head alloc1", 32'(alloc_preg1_o), 7);
        step(1, 1, 0, 0, 0, 0, 0);
        check("at head alloc0", 32'(alloc_preg0_o), 7);
        check("at head count", 32'(free_count_o), 1);
        check("at head stall", 32'(stall_o), 1);

        // Free of register 0 is ignored silently.
        step(1, 0, 0, 1, 0, 1, 0);
        check("free0 count", 32'(free_count_o), 1);
        check("free0 err", 32'(err_o), 0);

`ifdef FREE_LIST_CHECK_EN
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 40, 0, 0);
        check("dup free err", 32'(err_o), 1);
        check("dup free count", 32'(free_count_o), 32);
`endif

        // Overflow: the second free of the last pair is dropped.
        step(0, 0, 0, 0, 0, 0, 0);
        check("reset clears err", 32'(err_o), 0);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 1, 1 + 2*i, 1, 2 + 2*i);
        check("fill count", 32'(free_count_o), 62);
        step(1, 0, 0, 1, 31, 1, 32);
        check("overflow count", 32'(free_count_o), 63);
        check("overflow err", 32'(err_o), 1);
        check("overflow alloc0", 32'(alloc_preg0_o), 32);

        // Reset wins over a concurrent two-wide alloc/free.
        step(0, 1, 1, 1, 12, 1, 13);
        check("rst prio alloc0", 32'(alloc_preg0_o), 32);
        check("rst prio alloc1", 32'(alloc_preg1_o), 33);
        check("rst prio count", 32'(free_count_o), 32);
        check("rst prio stall", 32'(stall_o), 0);
        check("rst prio err", 32'(err_o), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NP-1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NP-1)));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
